// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding select
// encodings, the per-stage hazard record and the forwarding-controller FSM states.
package mips_ctrl_pkg;

  // Stage records carry register indices at a fixed width so the record type
  // can be shared; narrower indices are zero-extended on entry.
  localparam int REC_RD_W = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                vld;
    logic [REC_RD_W-1:0] rd;
    logic                wr;
    logic                ld;
  } stage_rec_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_t;

  // A stage can supply a forwarded value only if it holds a real instruction
  // that writes a register other than r0.
  function automatic logic is_src(input stage_rec_t rec);
    return rec.vld && rec.wr && (rec.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_cmp.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer of
// the source register, EX ahead of MEM.
module fwd_cmp
  import mips_ctrl_pkg::*;
(
  input  logic [REC_RD_W-1:0] src,
  input  logic                en,
  input  stage_rec_t          ex_rec,
  input  stage_rec_t          mem_rec,
  output logic [1:0]          sel
);

  always_comb begin
    sel = FWD_RF;
    if (en) begin
      if (is_src(ex_rec) && (ex_rec.rd == src)) begin
        sel = FWD_EXMEM;
      end else if (is_src(mem_rec) && (mem_rec.rd == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller: tracks the EX/MEM producers,
// registers the operand mux selects and inserts a one-cycle bubble on load-use.
module fwd_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_rec_t          ex_p1;
  stage_rec_t          mem_p2;
  fwd_state_t          state;
  logic [REC_RD_W-1:0] rs_x;
  logic [REC_RD_W-1:0] rt_x;
  logic [REC_RD_W-1:0] rd_x;
  logic [1:0]          sel_a_nxt;
  logic [1:0]          sel_b_nxt;

  assign rs_x = REC_RD_W'(id_rs);
  assign rt_x = REC_RD_W'(id_rt);
  assign rd_x = REC_RD_W'(id_rd);

  // Load in EX whose result the ID instruction needs: value not ready until after MEM.
  assign stall = id_valid && is_src(ex_p1) && ex_p1.ld &&
                 ((ex_p1.rd == rs_x) || (id_use_rt && (ex_p1.rd == rt_x)));

  assign bubble = (state == STALL);

  fwd_cmp u_cmp_a (
    .src     (rs_x),
    .en      (1'b1),
    .ex_rec  (ex_p1),
    .mem_rec (mem_p2),
    .sel     (sel_a_nxt)
  );

  fwd_cmp u_cmp_b (
    .src     (rt_x),
    .en      (id_use_rt),
    .ex_rec  (ex_p1),
    .mem_rec (mem_p2),
    .sel     (sel_b_nxt)
  );

  // ID -> EX (p1) -> MEM (p2) boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_p1     <= '0;
      mem_p2    <= '0;
      state     <= RUN;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      mem_p2 <= ex_p1;
      if (stall) begin
        ex_p1     <= '0;
        state     <= STALL;
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
        if (stall_cnt != '1) begin
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
      end else begin
        ex_p1     <= '{vld: id_valid, rd: rd_x, wr: id_regwrite, ld: id_memread};
        state     <= RUN;
        fwd_a_sel <= id_valid ? sel_a_nxt : FWD_RF;
        fwd_b_sel <= id_valid ? sel_b_nxt : FWD_RF;
      end
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed and randomized bench for fwd_ctrl against a queue-based model of
// the instructions occupying EX and MEM.
module tb_fwd_ctrl;

  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .bubble      (bubble),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } slot_t;

  // pipe[0] is the instruction in EX, pipe[1] the one in MEM.
  slot_t pipe[$];
  int    m_sel_a;
  int    m_sel_b;
  int    m_cnt;
  bit    m_bubble;
  int    checks;
  int    errors;

  function automatic bit producer(slot_t s);
    return s.v && s.wr && (s.rd != 0);
  endfunction

  function automatic int want_sel(int idx, bit en);
    if (!en) return 0;
    if (producer(pipe[0]) && pipe[0].rd == idx) return 1;
    if (producer(pipe[1]) && pipe[1].rd == idx) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    slot_t z;
    z = '{v: 0, rd: 0, wr: 0, ld: 0};
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    m_sel_a  = 0;
    m_sel_b  = 0;
    m_cnt    = 0;
    m_bubble = 0;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string name);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_stall);
    chk(32'(stall), 32'(exp_stall), {tag, "_stall"});
    chk(32'(bubble), 32'(m_bubble), {tag, "_bubble"});
    chk(32'(fwd_a_sel), 32'(m_sel_a), {tag, "_sel_a"});
    chk(32'(fwd_b_sel), 32'(m_sel_b), {tag, "_sel_b"});
    chk(32'(stall_cnt), 32'(m_cnt), {tag, "_cnt"});
  endtask

  // One clock: drive ID at the falling edge, check, then advance the model.
  task automatic cycle(input bit v, input int rs, input int rt, input bit urt,
                       input int rd, input bit wr, input bit ld,
                       input string tag, output bit st);
    bit    exp_stall;
    int    na, nb;
    slot_t ns;
    @(negedge clk);
    id_valid    = v;
    id_rs       = rs[REG_W-1:0];
    id_rt       = rt[REG_W-1:0];
    id_use_rt   = urt;
    id_rd       = rd[REG_W-1:0];
    id_regwrite = wr;
    id_memread  = ld;
    #1;
    exp_stall = v && producer(pipe[0]) && pipe[0].ld &&
                (pipe[0].rd == rs || (urt && pipe[0].rd == rt));
    check_outputs(tag, exp_stall);
    if (exp_stall) begin
      ns = '{v: 0, rd: 0, wr: 0, ld: 0};
      na = 0;
      nb = 0;
    end else begin
      ns = '{v: v, rd: rd, wr: wr, ld: ld};
      na = v ? want_sel(rs, 1'b1) : 0;
      nb = v ? want_sel(rt, urt) : 0;
    end
    @(posedge clk);
    pipe.push_front(ns);
    void'(pipe.pop_back());
    m_sel_a  = na;
    m_sel_b  = nb;
    m_bubble = exp_stall;
    if (exp_stall && m_cnt < CNT_MX) m_cnt++;
    st = exp_stall;
  endtask

  // Issue an instruction, holding it in ID for the extra cycle if it stalls.
  task automatic issue(input int rs, input int rt, input bit urt,
                       input int rd, input bit wr, input bit ld, input string tag);
    bit st;
    cycle(1'b1, rs, rt, urt, rd, wr, ld, tag, st);
    if (st) cycle(1'b1, rs, rt, urt, rd, wr, ld, {tag, "_held"}, st);
  endtask

  task automatic idle(input string tag);
    bit st;
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, tag, st);
  endtask

  initial begin
    bit st;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    id_use_rt   = 1'b0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
    model_reset();

    #12;
    check_outputs("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r3 followed by a reader of r3 in rs: EX/MEM forward, no stall
    issue(1, 2, 1'b1, 3, 1'b1, 1'b0, "add_r3");
    issue(3, 4, 1'b1, 6, 1'b1, 1'b0, "add_rs3");
    #1;
    chk(32'(fwd_a_sel), 32'd1, "r025_sel_a");
    chk(32'(stall_cnt), 32'd0, "r025_no_stall");

    // ADD r3, independent op, SUB reading r3 through rt: MEM/WB forward
    issue(1, 2, 1'b1, 3, 1'b1, 1'b0, "add_r3b");
    issue(8, 9, 1'b1, 10, 1'b1, 1'b0, "indep");
    issue(11, 3, 1'b1, 12, 1'b1, 1'b0, "sub_rt3");
    #1;
    chk(32'(fwd_b_sel), 32'd2, "r026_sel_b");
    chk(32'(fwd_a_sel), 32'd0, "r026_sel_a");

    // Load-use: one stall, one bubble, then MEM/WB forward
    issue(1, 0, 1'b0, 5, 1'b1, 1'b1, "lw_r5");
    issue(5, 0, 1'b0, 7, 1'b1, 1'b0, "add_rs5");
    #1;
    chk(32'(fwd_a_sel), 32'd2, "r027_sel_a");
    chk(32'(stall_cnt), 32'd1, "r027_cnt");
    chk(32'(bubble), 32'd0, "r027_bubble_gone");

    // r0 is never a producer, even for a load
    issue(1, 2, 1'b1, 0, 1'b1, 1'b0, "wr_r0_a");
    issue(1, 2, 1'b1, 0, 1'b1, 1'b1, "lw_r0");
    issue(0, 0, 1'b1, 9, 1'b1, 1'b0, "rd_r0");
    #1;
    chk(32'(fwd_a_sel), 32'd0, "r028_r0_a");
    chk(32'(fwd_b_sel), 32'd0, "r028_r0_b");
    chk(32'(stall_cnt), 32'd1, "r028_r0_nostall");

    // Both EX and MEM write r7: the newer EX value wins
    issue(1, 2, 1'b1, 7, 1'b1, 1'b0, "wr_r7_old");
    issue(1, 2, 1'b1, 7, 1'b1, 1'b0, "wr_r7_new");
    issue(7, 7, 1'b1, 9, 1'b1, 1'b0, "rd_r7");
    #1;
    chk(32'(fwd_a_sel), 32'd1, "r028_r7_a");
    chk(32'(fwd_b_sel), 32'd1, "r028_r7_b");
    idle("idle_a");
    idle("idle_b");

    // Reset while in STALL: outputs clear at once, first cycle after is plain RUN
    issue(1, 0, 1'b0, 5, 1'b1, 1'b1, "lw_r5_rst");
    cycle(1'b1, 5, 0, 1'b0, 7, 1'b1, 1'b0, "use_r5_rst", st);
    chk(32'(st), 32'd1, "rst_entered_stall");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("in_reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(5, 5, 1'b1, 7, 1'b1, 1'b0, "post_rst");
    #1;
    chk(32'(fwd_a_sel), 32'd0, "post_rst_sel_a");
    chk(32'(bubble), 32'd0, "post_rst_bubble");

    // 2^CNT_W+3 load-use pairs saturate the stall counter
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      issue(1, 0, 1'b0, 5, 1'b1, 1'b1, "sat_lw");
      issue(5, 0, 1'b0, 6, 1'b1, 1'b0, "sat_use");
    end
    #1;
    chk(32'(stall_cnt), 32'(CNT_MX), "r029_saturated");

    // Random traffic over a small register set to provoke frequent hazards
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            "rand", st);
    end
    idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameters SHALL be: REG_W, default 5, register-index width; CNT_W, default 16, stall-counter width.
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  single clock, all state on posedge
  rst_n  in  1  asynchronous, active-low reset
  id_valid  in  1  instruction present in ID
  id_rs  in  REG_W  ID source A index
  id_rt  in  REG_W  ID source B index
  id_use_rt  in  1  ID instruction reads rt
  id_rd  in  REG_W  ID destination index
  id_regwrite  in  1  ID instruction writes register file
  id_memread  in  1  ID instruction is a load
  fwd_a_sel  out  2  select for operand-A 3x1 mux
  fwd_b_sel  out  2  select for operand-B 3x1 mux
  stall  out  1  hold PC and IF/ID this cycle
  bubble  out  1  EX holds an inserted NOP this cycle
  stall_cnt  out  CNT_W  saturating count of stall cycles
REQ-003 Select encoding SHALL be: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 SHALL never be driven.

Function
REQ-004 Block SHALL track two internal stage records, EX and MEM, each holding vld, rd, wr, ld.
REQ-005 Each posedge with stall=0: EX <= {id_valid, id_rd, id_regwrite, id_memread}; MEM <= EX.
REQ-006 Each posedge with stall=1: EX <= all-zero bubble; MEM <= EX.
REQ-007 A record SHALL be a forwarding source only if vld=1, wr=1, rd!=0.
REQ-008 stall SHALL be combinational: 1 iff id_valid and EX is a source with ld=1 and (EX.rd==id_rs or (id_use_rt and EX.rd==id_rt)).
REQ-009 FSM SHALL have states RUN and STALL; RUN->STALL when stall=1 at posedge; STALL->RUN unconditionally next posedge.
REQ-010 In STALL the just-inserted bubble in EX SHALL make the REQ-008 condition false, so stall never exceeds one consecutive cycle per load.
REQ-011 bubble SHALL be 1 exactly while state=STALL.
REQ-012 fwd_a_sel SHALL be registered: on a posedge with stall=0 and id_valid=1 it loads 01 if EX is a source and EX.rd==id_rs, else 10 if MEM is a source and MEM.rd==id_rs, else 00.
REQ-013 fwd_b_sel SHALL follow REQ-012 using id_rt, gated by id_use_rt (00 when id_use_rt=0).
REQ-014 On a posedge with stall=1 or id_valid=0 both selects SHALL load 00.
REQ-015 EX SHALL take priority over MEM when both match (newest value wins).
REQ-016 Register 0 SHALL never be forwarded nor cause a stall.
REQ-017 stall_cnt SHALL increment on each posedge with stall=1 and saturate at all-ones.
REQ-018 Selects SHALL be valid during the cycle the instruction occupies EX, one cycle after REQ-012 sampling.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear EX and MEM records, state to RUN, fwd_a_sel=00, fwd_b_sel=00, stall_cnt=0.
REQ-020 During reset stall=0 and bubble=0.
REQ-021 Reset asserted mid-stall SHALL abandon the stall; first post-reset cycle SHALL be RUN with no forwarding.

Structure
REQ-022 Select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the stage-record type SHALL live in shared package mips_ctrl_pkg.
REQ-023 One sub-module fwd_cmp SHALL compute a 2-bit select for one operand from (src index, enable, EX record, MEM record); instantiated twice.
REQ-024 Implementation SHALL have no latches and no combinational path from selects to stall.

Verification
REQ-025 ADD r3 then ADD using rs=r3 -> second instruction's EX cycle fwd_a_sel=01, stall never asserted.
REQ-026 ADD r3, independent op, SUB rt=r3 (id_use_rt=1) -> fwd_b_sel=10 in SUB's EX cycle.
REQ-027 LW r5 then ADD rs=r5 -> stall=1 one cycle, bubble=1 next cycle, then fwd_a_sel=10, stall_cnt=1.
REQ-028 Writes to r0 followed by readers of r0 -> selects 00, no stall; EX and MEM both writing r7 then reader r7 -> 01.
REQ-029 Assert rst_n=0 during STALL -> all outputs 00/0 immediately; 2^CNT_W+3 load-use pairs -> stall_cnt holds all-ones.
